// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the bus-side bridges.
//   AXI_BURST_INCR / AXI_SIZE_4B / AXI_RESP_OKAY : encodings used on AR/R
//   axi_ar_t : AR channel payload (id, addr, len, size, burst)
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ar_t;
endpackage

// File: rtl/flop.sv
// Generic enabled register with asynchronous active-high reset to zero.
//   clk, rst : clock, async reset
//   en, d    : load enable and data
//   q        : registered value
module flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache refill port to AXI4 read bridge. Each accepted word
// request becomes a single-beat AXI read; data returns in request order.
// Up to MAX_OUTSTANDING reads may be in flight.
//   clk, reset                 : clock, async active-high reset
//   mem_req / mem_read_addr    : cache word read request
//   mem_addr_ok                : request accepted this cycle (combinational)
//   mem_read_data/mem_data_ok  : returned word, one-cycle valid pulse
//   bus_err                    : sticky, set on a non-OKAY response
//   ar* / r*                   : AXI4 AR and R channels
module icache_axi_rd_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID          = 4'd0,
  parameter int         MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic [31:0] mem_read_addr,
  output logic        mem_addr_ok,
  output logic [31:0] mem_read_data,
  output logic        mem_data_ok,
  output logic        bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt;
  logic [31:0]   ar_addr_q;
  logic          ar_valid_q;
  logic          accept, ar_fire, r_fire;
  axi_ar_t       ar;

  // Single ID, single beat: ordering is implicit, so rid/rlast carry nothing.
  logic unused_r;
  assign unused_r = ^{rid, rlast, mem_read_addr[1:0]};

  assign rready = ~reset;

  // cnt is compared before its update, so a return in the same cycle does
  // not open a slot until the next cycle.
  assign accept      = ~reset & mem_req & (cnt < CNT_MAX) & (~ar_valid_q | arready);
  assign mem_addr_ok = accept;
  assign ar_fire     = ar_valid_q & arready;
  // Beats arriving with nothing outstanding are leftovers from before a
  // reset: consume them (rready=1) but never count or forward them.
  assign r_fire      = rvalid & rready & (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
    end else if (accept) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= {mem_read_addr[31:2], 2'b00};
    end else if (ar_fire) begin
      ar_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else begin
      case ({accept, r_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  bus_err <= 1'b0;
    else if (r_fire && rresp != AXI_RESP_OKAY) bus_err <= 1'b1;
  end

  always_comb begin
    ar       = '0;
    ar.id    = AXI_ID;
    ar.addr  = ar_addr_q;
    ar.len   = 8'd0;
    ar.size  = AXI_SIZE_4B;
    ar.burst = AXI_BURST_INCR;
  end

  assign arid    = ar.id;
  assign araddr  = ar.addr;
  assign arlen   = ar.len;
  assign arsize  = ar.size;
  assign arburst = ar.burst;
  assign arvalid = ar_valid_q;

  flop #(.W(32)) u_rdata (
    .clk(clk), .rst(reset), .en(r_fire), .d(rdata), .q(mem_read_data)
  );

  flop #(.W(1)) u_dok (
    .clk(clk), .rst(reset), .en(1'b1), .d(r_fire), .q(mem_data_ok)
  );
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
module tb_icache_axi_rd_bridge;
  localparam int         MAX    = 4;
  localparam logic [3:0] AXI_ID = 4'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_read_addr;
  logic        mem_addr_ok;
  logic [31:0] mem_read_data;
  logic        mem_data_ok;
  logic        bus_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  icache_axi_rd_bridge #(.AXI_ID(AXI_ID), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_read_addr(mem_read_addr),
    .mem_addr_ok(mem_addr_ok), .mem_read_data(mem_read_data), .mem_data_ok(mem_data_ok),
    .bus_err(bus_err), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dok_seen = 0;

  // reference model: spec-level view of the bridge
  logic [31:0] pend[$];      // accepted, not yet returned (request order)
  int          m_cnt;
  bit          m_arvalid;
  logic [31:0] m_araddr;
  bit          m_dok;
  logic [31:0] m_rdata;
  bit          m_err;
  bit          last_acc, last_fire;

  // AXI slave model
  logic [31:0] ar_q[$];
  logic [31:0] mem_img[logic [31:0]];
  bit          r_taken;
  int          r_pct = 100;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic mon();
    bit exp_ok, fire;
    logic [31:0] pa;
    cyc++;
    if (reset) begin
      checks++;
      if (arvalid !== 1'b0 || araddr !== 32'h0 || mem_data_ok !== 1'b0 ||
          mem_read_data !== 32'h0 || bus_err !== 1'b0 || rready !== 1'b0 || dut.cnt !== '0) begin
        failures++;
        $display("FAIL reset_state arvalid=%b araddr=%h dok=%b rdata=%h err=%b rready=%b cnt=%0d want all 0",
                 arvalid, araddr, mem_data_ok, mem_read_data, bus_err, rready, dut.cnt);
      end
      pend.delete();
      m_cnt = 0; m_arvalid = 0; m_araddr = 0; m_dok = 0; m_rdata = 0; m_err = 0;
      r_taken = 0; last_acc = 0; last_fire = 0;
      return;
    end
    exp_ok = mem_req && (m_cnt < MAX) && (!m_arvalid || arready);
    checks++;
    if (mem_addr_ok !== exp_ok) begin
      failures++;
      $display("FAIL addr_ok cyc=%0d got=%b want=%b", cyc, mem_addr_ok, exp_ok);
    end
    checks++;
    if (arvalid !== m_arvalid || (m_arvalid && araddr !== m_araddr)) begin
      failures++;
      $display("FAIL ar_reg cyc=%0d got v=%b a=%h want v=%b a=%h", cyc, arvalid, araddr, m_arvalid, m_araddr);
    end
    checks++;
    if (mem_data_ok !== m_dok || (m_dok && mem_read_data !== m_rdata)) begin
      failures++;
      $display("FAIL data_ret cyc=%0d got ok=%b d=%h want ok=%b d=%h", cyc, mem_data_ok, mem_read_data, m_dok, m_rdata);
    end
    checks++;
    if (bus_err !== m_err) begin
      failures++;
      $display("FAIL bus_err cyc=%0d got=%b want=%b", cyc, bus_err, m_err);
    end
    checks++;
    if (int'(dut.cnt) != m_cnt || int'(dut.cnt) > MAX) begin
      failures++;
      $display("FAIL cnt cyc=%0d got=%0d want=%0d", cyc, dut.cnt, m_cnt);
    end
    checks++;
    if (arlen !== 8'd0 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== AXI_ID || rready !== 1'b1) begin
      failures++;
      $display("FAIL const_out got len=%h size=%b burst=%b id=%h rready=%b want 00/010/01/%h/1",
               arlen, arsize, arburst, arid, rready, AXI_ID);
    end
    if (mem_data_ok === 1'b1) dok_seen++;
    if (arvalid && arready) ar_q.push_back(araddr);
    r_taken = rvalid && rready;
    fire = rvalid && (m_cnt > 0);
    last_fire = fire;
    last_acc = exp_ok;
    if (fire) begin
      pa = pend.pop_front();
      m_rdata = data_of(pa);
      if (pa == err_addr) m_err = 1;
    end
    m_dok = fire;
    if (exp_ok) begin
      m_araddr = {mem_read_addr[31:2], 2'b00};
      m_arvalid = 1;
      pend.push_back(m_araddr);
    end else if (m_arvalid && arready) m_arvalid = 0;
    m_cnt = m_cnt + int'(exp_ok) - int'(fire);
  endtask

  task automatic slave_drive();
    logic [31:0] a;
    if (r_taken) rvalid = 0;
    if (!rvalid && ar_q.size() > 0 && $urandom_range(0, 99) < r_pct) begin
      a = ar_q.pop_front();
      rvalid = 1;
      rdata = data_of(a);
      rresp = (a == err_addr) ? 2'b10 : 2'b00;
      rid = 4'($urandom);
      rlast = 1;
    end
  endtask

  // one clock: sample/check at negedge, drive just after posedge
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    slave_drive();
  endtask

  task automatic drain();
    int n = 0;
    mem_req = 0; arready = 1; r_pct = 100;
    while (!(m_cnt == 0 && !m_arvalid && ar_q.size() == 0 && !rvalid && !m_dok) && n < 300) begin
      step(); n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout cnt=%0d got no idle within 300 cycles want idle", m_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) step();
    reset = 0;
    step();
  endtask

  task automatic test_single();
    int got = -1;
    logic [31:0] gd = 0;
    mem_img[32'h1FC0_0104] = 32'hDEAD_BEEF;
    arready = 1; r_pct = 100;
    mem_req = 1; mem_read_addr = 32'h1FC0_0104;
    step();
    mem_req = 0;
    checks++;
    if (!last_acc) begin failures++; $display("FAIL single_accept got=0 want=1"); end
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1FC0_0104) begin
      failures++; $display("FAIL single_araddr got v=%b a=%h want 1/1fc00104", arvalid, araddr);
    end
    for (int k = 1; k <= 8; k++) begin
      if (mem_data_ok === 1'b1 && got < 0) begin got = k; gd = mem_read_data; end
      step();
    end
    checks++;
    if (got != 3 || gd !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL single_latency got T+%0d data=%h want T+3 data=deadbeef", got, gd);
    end
    drain();
  endtask

  task automatic test_refill();
    logic [31:0] base = $urandom & ~32'hF;
    int d0 = dok_seen;
    arready = 1; r_pct = 40;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1; mem_read_addr = base + 32'(4 * i);
      step();
      checks++;
      if (!last_acc) begin failures++; $display("FAIL refill_consec beat=%0d got accept=0 want 1", i); end
    end
    mem_req = 0;
    drain();
    checks++;
    if (dok_seen - d0 != 4) begin
      failures++; $display("FAIL refill_pulses got=%0d want=4", dok_seen - d0);
    end
  endtask

  task automatic test_full();
    int fire_c = -1, acc_c = -1;
    arready = 1; r_pct = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1; mem_read_addr = $urandom;
      step();
    end
    mem_req = 1; mem_read_addr = $urandom;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (last_acc || int'(dut.cnt) != MAX) begin
        failures++; $display("FAIL full_block got acc=%b cnt=%0d want acc=0 cnt=4", last_acc, dut.cnt);
      end
    end
    r_pct = 100;
    for (int i = 0; i < 20 && acc_c < 0; i++) begin
      step();
      if (last_fire && fire_c < 0) fire_c = cyc;
      if (last_acc) acc_c = cyc;
    end
    mem_req = 0;
    checks++;
    if (fire_c < 0 || acc_c != fire_c + 1) begin
      failures++; $display("FAIL full_unblock got fire=%0d acc=%0d want acc=fire+1", fire_c, acc_c);
    end
    drain();
  endtask

  task automatic test_ar_stall();
    logic [31:0] s0;
    logic [31:0] b = $urandom;
    arready = 0; r_pct = 100;
    mem_req = 1; mem_read_addr = $urandom;
    step();
    mem_read_addr = b;
    s0 = araddr;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (last_acc || araddr !== s0 || arvalid !== 1'b1) begin
        failures++; $display("FAIL ar_stall got acc=%b a=%h v=%b want 0/%h/1", last_acc, araddr, arvalid, s0);
      end
    end
    arready = 1;
    step();
    mem_req = 0;
    checks++;
    if (!last_acc || araddr !== {b[31:2], 2'b00}) begin
      failures++; $display("FAIL ar_release got acc=%b a=%h want 1/%h", last_acc, araddr, {b[31:2], 2'b00});
    end
    drain();
  endtask

  task automatic test_simul();
    int c0;
    arready = 1; r_pct = 100;
    mem_req = 1; mem_read_addr = $urandom;
    step();
    mem_req = 0;
    step();
    mem_req = 1; mem_read_addr = $urandom;
    c0 = int'(dut.cnt);
    step();
    mem_req = 0;
    checks++;
    if (!(last_acc && last_fire) || c0 != 1 || int'(dut.cnt) != 1) begin
      failures++;
      $display("FAIL simul_cnt got acc=%b fire=%b cnt %0d->%0d want 1 1 1->1", last_acc, last_fire, c0, dut.cnt);
    end
    drain();
  endtask

  task automatic test_error();
    err_addr = $urandom & ~32'h3;
    arready = 1;
    mem_req = 1; mem_read_addr = err_addr;
    step();
    mem_req = 0;
    drain();
    checks++;
    if (bus_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", bus_err); end
    mem_req = 1; mem_read_addr = err_addr ^ 32'h100;
    step();
    mem_req = 0;
    drain();
    checks++;
    if (bus_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", bus_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) r_pct = $urandom_range(30, 100);
      mem_req = ($urandom_range(0, 99) < 60);
      mem_read_addr = $urandom;
      arready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int d0;
    arready = 1; r_pct = 0;
    for (int i = 0; i < 2; i++) begin
      mem_req = 1; mem_read_addr = $urandom;
      step();
    end
    mem_req = 0;
    step();
    reset = 1;
    repeat (2) step();
    reset = 0;
    d0 = dok_seen;
    r_pct = 100;
    repeat (8) step();
    checks++;
    if (dok_seen != d0 || dut.cnt !== '0 || ar_q.size() != 0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_stale got pulses=%0d cnt=%0d left=%0d err=%b want 0/0/0/0",
               dok_seen - d0, dut.cnt, ar_q.size(), bus_err);
    end
  endtask

  initial begin
    reset = 1; mem_req = 0; mem_read_addr = 0; arready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0; r_taken = 0;
    test_reset();
    test_single();
    test_refill();
    test_full();
    test_ar_stall();
    test_simul();
    test_error();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
